// File: rtl/priority_to_onehot_tree.sv
// Registered LSB-first priority encoder.
// Returns the index of the lowest set bit of dec_vld and a valid flag one clock later.
// IMPLEMENTATION selects the structure:
//   0 = SPLIT-ary tree of ordered muxes, log_SPLIT(WIDTH) levels deep
//   1 = flat linear scan
// Both structures produce identical outputs.
module priority_to_onehot_tree #(
    parameter int WIDTH          = 16,
    parameter int SPLIT          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         dec_vld,
    output logic [$clog2(WIDTH)-1:0] enc_idx,
    output logic                     enc_vld
);

    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int SPLIT_LOG = $clog2(SPLIT);
    // The tree always works on a power of SPLIT.
    // A narrower WIDTH is zero-padded up to that size.
    localparam int LEVELS  = (WIDTH_LOG + SPLIT_LOG - 1) / SPLIT_LOG;
    localparam int PAD_LOG = LEVELS * SPLIT_LOG;
    localparam int PAD_W   = 1 << PAD_LOG;
    localparam int LEAVES  = PAD_W / SPLIT;

    // Reject illegal parameter sets while the design is being elaborated.
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "priority_to_onehot_tree: WIDTH must be a power of two >= 2");
    end
    if (SPLIT < 2 || SPLIT > WIDTH || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
        $fatal(1, "priority_to_onehot_tree: SPLIT must be a power of two in [2, WIDTH]");
    end
    if (IMPLEMENTATION != 0 && IMPLEMENTATION != 1) begin : g_bad_impl
        $fatal(1, "priority_to_onehot_tree: IMPLEMENTATION must be 0 or 1");
    end

    logic [WIDTH_LOG-1:0] enc_idx_d, enc_idx_q;
    logic                 enc_vld_d, enc_vld_q;

    if (IMPLEMENTATION == 0) begin : g_tree
        logic [PAD_W-1:0]   pad_vec;
        logic [PAD_LOG-1:0] node_idx [LEAVES];
        logic               node_vld [LEAVES];

        // Build the tree bottom-up, one level at a time.
        // Each level overwrites the array in place.
        // Node n reads entries n*SPLIT.. before it writes entry n,
        // so every child it needs is still unmodified.
        always_comb begin
            logic [PAD_LOG-1:0] sel_idx;
            logic               sel_vld;
            // NOTE: every variable gets a default before any conditional write.
            // Without this, synthesis infers latches for the paths that skip an assignment.
            sel_idx = '0;
            sel_vld = 1'b0;
            pad_vec = PAD_W'(dec_vld);
            for (int n = 0; n < LEAVES; n++) begin
                node_idx[n] = '0;
                node_vld[n] = 1'b0;
            end

            // NOTE: blocking assignments are used here on purpose.
            // Each step reads the value just computed in the same pass.
            // The !vld guard makes this an ordered if/else chain:
            // once a lower bit wins, undefined higher bits are never consulted.
            for (int n = 0; n < LEAVES; n++) begin
                for (int b = 0; b < SPLIT; b++) begin
                    if (!node_vld[n] && pad_vec[n*SPLIT + b]) begin
                        node_vld[n] = 1'b1;
                        node_idx[n] = PAD_LOG'(b);
                    end
                end
            end

            // Each upper level prepends the winning child's number above that child's index.
            for (int l = 1; l < LEVELS; l++) begin
                for (int n = 0; n < (LEAVES >> (l * SPLIT_LOG)); n++) begin
                    sel_vld = 1'b0;
                    sel_idx = '0;
                    for (int k = 0; k < SPLIT; k++) begin
                        if (!sel_vld && node_vld[n*SPLIT + k]) begin
                            sel_vld = 1'b1;
                            sel_idx = (PAD_LOG'(k) << (l * SPLIT_LOG)) | node_idx[n*SPLIT + k];
                        end
                    end
                    node_vld[n] = sel_vld;
                    node_idx[n] = sel_idx;
                end
            end

            enc_vld_d = node_vld[0];
            enc_idx_d = node_idx[0][WIDTH_LOG-1:0];
        end
    end else begin : g_flat
        // Scan from bit 0 upward; the first set bit wins.
        always_comb begin
            enc_vld_d = 1'b0;
            enc_idx_d = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (!enc_vld_d && dec_vld[i]) begin
                    enc_vld_d = 1'b1;
                    enc_idx_d = WIDTH_LOG'(i);
                end
            end
        end
    end

    // Capture the encoded result.
    // Reset clears it at once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for state.
        // All registers then update together, with no order dependence between processes.
        if (rst) begin
            enc_idx_q <= '0;
            enc_vld_q <= 1'b0;
        end else begin
            enc_idx_q <= enc_idx_d;
            enc_vld_q <= enc_vld_d;
        end
    end

    assign enc_idx = enc_idx_q;
    assign enc_vld = enc_vld_q;

endmodule

// File: tb/tb_priority_to_onehot_tree.sv
// Bench for priority_to_onehot_tree.
// Four (WIDTH, SPLIT) configurations run side by side: (16,4), (8,2), (32,4), (64,8).
// Each configuration is instantiated with both implementations.
// Every cycle, every instance is compared against a lowest-set-bit scan model delayed by one clock.
// Literal expectations pin the main scenarios.
module tb_priority_to_onehot_tree;

    logic        clk;
    logic        rst;
    logic        chk_en;
    logic [15:0] d16;
    logic [7:0]  d8;
    logic [31:0] d32;
    logic [63:0] d64;

    logic [3:0] i16t, i16f;
    logic [2:0] i8t,  i8f;
    logic [4:0] i32t, i32f;
    logic [5:0] i64t, i64f;
    logic v16t, v16f, v8t, v8f, v32t, v32f, v64t, v64f;

    // Model results, packed as {vld, idx[5:0]}.
    logic [6:0] e16, e8, e32, e64;

    int n_checks;
    int n_fail;

    priority_to_onehot_tree #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0)) u16t (.clk(clk), .rst(rst), .dec_vld(d16), .enc_idx(i16t), .enc_vld(v16t));
    priority_to_onehot_tree #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(1)) u16f (.clk(clk), .rst(rst), .dec_vld(d16), .enc_idx(i16f), .enc_vld(v16f));
    priority_to_onehot_tree #(.WIDTH(8),  .SPLIT(2), .IMPLEMENTATION(0)) u8t  (.clk(clk), .rst(rst), .dec_vld(d8),  .enc_idx(i8t),  .enc_vld(v8t));
    priority_to_onehot_tree #(.WIDTH(8),  .SPLIT(2), .IMPLEMENTATION(1)) u8f  (.clk(clk), .rst(rst), .dec_vld(d8),  .enc_idx(i8f),  .enc_vld(v8f));
    priority_to_onehot_tree #(.WIDTH(32), .SPLIT(4), .IMPLEMENTATION(0)) u32t (.clk(clk), .rst(rst), .dec_vld(d32), .enc_idx(i32t), .enc_vld(v32t));
    priority_to_onehot_tree #(.WIDTH(32), .SPLIT(4), .IMPLEMENTATION(1)) u32f (.clk(clk), .rst(rst), .dec_vld(d32), .enc_idx(i32f), .enc_vld(v32f));
    priority_to_onehot_tree #(.WIDTH(64), .SPLIT(8), .IMPLEMENTATION(0)) u64t (.clk(clk), .rst(rst), .dec_vld(d64), .enc_idx(i64t), .enc_vld(v64t));
    priority_to_onehot_tree #(.WIDTH(64), .SPLIT(8), .IMPLEMENTATION(1)) u64f (.clk(clk), .rst(rst), .dec_vld(d64), .enc_idx(i64f), .enc_vld(v64f));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: index of the first bit that is definitely 1.
    function automatic logic [6:0] scan(input logic [63:0] v, input int w);
        for (int i = 0; i < w; i++) begin
            if (v[i] === 1'b1) return {1'b1, 6'(i)};
        end
        return 7'd0;
    endfunction

    // Random vector biased toward having its lowest set bit at any position.
    function automatic logic [63:0] rnd_vec(input int w);
        logic [63:0] v;
        if ($urandom_range(0, 15) == 0) return 64'd0;
        v = {$urandom(), $urandom()};
        v = v & (~64'd0 << $urandom_range(0, w - 1));
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string name, input logic vld, input logic [5:0] idx, input logic [6:0] e);
        check({name, ".vld"}, 64'(vld), 64'(e[6]));
        check({name, ".idx"}, 64'(idx), 64'(e[5:0]));
    endtask

    task automatic lit16(input string name, input logic vld, input int idx);
        check({name, ".tree.vld"}, 64'(v16t), 64'(vld));
        check({name, ".tree.idx"}, 64'(i16t), 64'(idx));
        check({name, ".flat.vld"}, 64'(v16f), 64'(vld));
        check({name, ".flat.idx"}, 64'(i16f), 64'(idx));
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".16t"}, {57'd0, v16t, 2'd0, i16t}, 64'd0);
        check({name, ".16f"}, {57'd0, v16f, 2'd0, i16f}, 64'd0);
        check({name, ".8t"},  {57'd0, v8t,  3'd0, i8t},  64'd0);
        check({name, ".8f"},  {57'd0, v8f,  3'd0, i8f},  64'd0);
        check({name, ".32t"}, {57'd0, v32t, 1'd0, i32t}, 64'd0);
        check({name, ".32f"}, {57'd0, v32f, 1'd0, i32f}, 64'd0);
        check({name, ".64t"}, {57'd0, v64t, i64t},       64'd0);
        check({name, ".64f"}, {57'd0, v64f, i64f},       64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle-delayed model; reset clears the expectation immediately, as it does in the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e16 <= 7'd0; e8 <= 7'd0; e32 <= 7'd0; e64 <= 7'd0;
        end else begin
            e16 <= scan(64'(d16), 16);
            e8  <= scan(64'(d8),  8);
            e32 <= scan(64'(d32), 32);
            e64 <= scan(d64,      64);
        end
    end

    // Compare every instance against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("w16_tree", v16t, 6'(i16t), e16);
            cmp("w16_flat", v16f, 6'(i16f), e16);
            cmp("w8_tree",  v8t,  6'(i8t),  e8);
            cmp("w8_flat",  v8f,  6'(i8f),  e8);
            cmp("w32_tree", v32t, 6'(i32t), e32);
            cmp("w32_flat", v32f, 6'(i32f), e32);
            cmp("w64_tree", v64t, i64t,     e64);
            cmp("w64_flat", v64f, i64f,     e64);
        end
    end

    initial begin
        logic [15:0] xv;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst      = 1'b0;
        d16 = 16'hFFFF; d8 = 8'hFF; d32 = 32'hFFFF_FFFF; d64 = ~64'd0;

        // Pin the model with hand-computed values.
        check("model_A0C0", 64'(scan(64'h0000_0000_0000_A0C0, 16)), 64'h46);
        check("model_8000", 64'(scan(64'h0000_0000_0000_8000, 16)), 64'h4F);
        check("model_zero", 64'(scan(64'h0, 16)), 64'h00);
        check("model_w32_top", 64'(scan(64'h0000_0000_8000_0000, 32)), 64'h5F);

        // Load a valid result, then reset between edges: outputs must clear at once.
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        chk_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            lit16("rst_hold", 1'b0, 0);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        step();
        lit16("rst_release", 1'b1, 0);

        // Idle and spot checks.
        d16 = 16'h0000; step(); lit16("idle", 1'b0, 0);
        d16 = 16'hA0C0; step(); lit16("spot_A0C0", 1'b1, 6);
        d16 = 16'h8000; step(); lit16("spot_8000", 1'b1, 15);
        d16 = 16'hFFFF; step(); lit16("spot_FFFF", 1'b1, 0);

        // One-hot sweep.
        for (int i = 0; i < 16; i++) begin
            d16 = 16'd1 << i;
            step();
            lit16($sformatf("onehot_%0d", i), 1'b1, i);
        end

        // Winner bit followed by undefined higher bits.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (j < i)       xv[j] = 1'b0;
                else if (j == i) xv[j] = 1'b1;
                else             xv[j] = 1'bx;
            end
            d16 = xv;
            step();
            lit16($sformatf("xprio_%0d", i), 1'b1, i);
        end

        // Reset mid-stream discards the in-flight result.
        d16 = 16'h8000;
        step();
        #2;
        rst = 1'b1;
        #1;
        lit16("rst_mid", 1'b0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step();
        lit16("rst_mid_release", 1'b1, 15);

        // Exhaustive 16-bit sweep; the other widths get random vectors on the same cycles.
        for (int v = 0; v < 65536; v++) begin
            d16 = 16'(v);
            d8  = 8'(rnd_vec(8));
            d32 = 32'(rnd_vec(32));
            d64 = rnd_vec(64);
            step();
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
